layer_pass_scheduler: RTL and testbench

- Layer-level sequencer that sits directly upstream of the per-pass NoC controller.
- Iterates a convolution layer over M (filter-group) passes × C (channel-group) passes. For each pass it:
  - triggers a GLB/scratchpad load;
  - starts one pass on the pass controller and waits for it to finish.
- Exports pass indices and psum accumulate/last flags to the datapath.
- Signals layer completion to the top-level controller.

---
 rtl/layer_pass_scheduler.sv | 109 ++++++++++
 tb/tb_layer_pass_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_pass_scheduler.sv
// rtl/layer_pass_scheduler.sv - M x C layer pass sequencer ahead of the pass controller
module layer_pass_scheduler #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_m_passes,
   input  logic [CNT_W-1:0] num_c_passes,
   output logic             load_start,
   input  logic             load_done,
   output logic             pass_start,
   input  logic             pass_done,
   output logic [CNT_W-1:0] m_idx,
   output logic [CNT_W-1:0] c_idx,
   output logic             psum_accum,
   output logic             last_c,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_LOAD,
      PASS,
      WAIT_PASS,
      ADVANCE,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] m_cnt, c_cnt;
   logic [CNT_W-1:0] m_cnt_nxt, c_cnt_nxt;
   logic [CNT_W-1:0] m_idx_nxt, c_idx_nxt;
   logic [CNT_W-1:0] m_last, c_last;

   // Last legal index per loop; counts are never latched as zero, so no wrap occurs
   assign m_last = m_cnt - ONE;
   assign c_last = c_cnt - ONE;

   // State, indices and latched counts advance on the falling edge like the pass controller
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         m_idx <= '0;
         c_idx <= '0;
         m_cnt <= '0;
         c_cnt <= '0;
      end else begin
         state <= state_nxt;
         m_idx <= m_idx_nxt;
         c_idx <= c_idx_nxt;
         m_cnt <= m_cnt_nxt;
         c_cnt <= c_cnt_nxt;
      end
   end

   // Next-state logic: C is the inner loop, M the outer loop
   always_comb begin
      state_nxt = state;
      m_idx_nxt = m_idx;
      c_idx_nxt = c_idx;
      m_cnt_nxt = m_cnt;
      c_cnt_nxt = c_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               m_cnt_nxt = (num_m_passes == '0) ? ONE : num_m_passes;
               c_cnt_nxt = (num_c_passes == '0) ? ONE : num_c_passes;
               m_idx_nxt = '0;
               c_idx_nxt = '0;
               state_nxt = LOAD;
            end
         end
         LOAD:      state_nxt = WAIT_LOAD;
         WAIT_LOAD: if (load_done) state_nxt = PASS;
         PASS:      state_nxt = WAIT_PASS;
         WAIT_PASS: if (pass_done) state_nxt = ADVANCE;
         ADVANCE: begin
            if (c_idx < c_last) begin
               c_idx_nxt = c_idx + ONE;
               state_nxt = LOAD;
            end else if (m_idx < m_last) begin
               c_idx_nxt = '0;
               m_idx_nxt = m_idx + ONE;
               state_nxt = LOAD;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Moore-decoded strobes and status
   assign load_start = (state == LOAD);
   assign pass_start = (state == PASS);
   assign done       = (state == DONE);
   assign busy       = (state != IDLE) && (state != DONE);

   // Psum control follows the channel-group index
   assign psum_accum = (c_idx != '0);
   assign last_c     = (c_idx == c_last);

endmodule

// File: tb/tb_layer_pass_scheduler.sv
// tb/tb_layer_pass_scheduler.sv - randomized self-checking bench for layer_pass_scheduler
module tb_layer_pass_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] num_m_passes;
   logic [7:0] num_c_passes;
   logic       load_start;
   logic       load_done;
   logic       pass_start;
   logic       pass_done;
   logic [7:0] m_idx;
   logic [7:0] c_idx;
   logic       psum_accum;
   logic       last_c;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int rst_last_c;

   layer_pass_scheduler #(.CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_m_passes (num_m_passes),
      .num_c_passes (num_c_passes),
      .load_start   (load_start),
      .load_done    (load_done),
      .pass_start   (pass_start),
      .pass_done    (pass_done),
      .m_idx        (m_idx),
      .c_idx        (c_idx),
      .psum_accum   (psum_accum),
      .last_c       (last_c),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // DUT acts on negedge; sampling and driving happen on posedge
   task automatic step();
      @(posedge clk);
      cyc++;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_load_start"}, 32'(load_start), 0);
      check({tag, "_pass_start"}, 32'(pass_start), 0);
      check({tag, "_busy"},       32'(busy), 0);
      check({tag, "_done"},       32'(done), 0);
      check({tag, "_m_idx"},      32'(m_idx), 0);
      check({tag, "_c_idx"},      32'(c_idx), 0);
      check({tag, "_psum_accum"}, 32'(psum_accum), 0);
      check({tag, "_last_c"},     32'(last_c), 32'(rst_last_c));
   endtask

   // Runs one layer, acting as load/pass responder and checking against the loop model
   task automatic run_layer(input int m_in, input int c_in, input int ld_dly, input int pd_dly,
                            input bit ld_tied, input bit inject, input int abort_pass);
      int m_eff, c_eff, total, budget;
      int n_load, n_pass, n_done;
      int exp_load_t, exp_pass_t, exp_done_t;
      int ld_t, pd_t, inj_t, abort_t;
      int im, ic;
      bit fin, aborted;
      m_eff = (m_in == 0) ? 1 : m_in;
      c_eff = (c_in == 0) ? 1 : c_in;
      total = m_eff * c_eff;
      budget = total * (ld_dly + pd_dly + 6) + 20;
      n_load = 0; n_pass = 0; n_done = 0;
      exp_pass_t = -1; exp_done_t = -1;
      ld_t = -1; pd_t = -1; inj_t = -1; abort_t = -1;
      fin = 0; aborted = 0;

      num_m_passes = 8'(m_in);
      num_c_passes = 8'(c_in);
      start = 1'b1;
      exp_load_t = cyc + 1;
      step();
      start = 1'b0;
      num_m_passes = 8'($urandom);
      num_c_passes = 8'($urandom);

      for (int k = 0; k < budget && !fin; k++) begin
         if (cyc == abort_t) begin
            reset = 1'b1;
            #1;
            check_reset_state("abort_now");
            step();
            check_reset_state("abort_next");
            reset = 1'b0;
            aborted = 1;
            break;
         end
         check("busy", 32'(busy), 32'(cyc != exp_done_t));
         if (load_start) begin
            im = n_load / c_eff;
            ic = n_load % c_eff;
            check("load_cycle", 32'(cyc), 32'(exp_load_t));
            check("load_m_idx", 32'(m_idx), 32'(im));
            check("load_c_idx", 32'(c_idx), 32'(ic));
            check("psum_accum", 32'(psum_accum), 32'(ic != 0));
            check("last_c",     32'(last_c), 32'(ic == c_eff - 1));
            n_load++;
            ld_t = ld_tied ? cyc + 1 : cyc + ld_dly;
            exp_pass_t = ld_t + 1;
            if (inject && n_load == 1) inj_t = cyc + 1;
         end
         if (pass_start) begin
            check("pass_cycle", 32'(cyc), 32'(exp_pass_t));
            check("pass_m_idx", 32'(m_idx), 32'(n_pass / c_eff));
            check("pass_c_idx", 32'(c_idx), 32'(n_pass % c_eff));
            n_pass++;
            pd_t = cyc + pd_dly;
            if (n_pass < total) exp_load_t = pd_t + 2;
            else                exp_done_t = pd_t + 2;
            if (abort_pass == n_pass) abort_t = cyc + 1;
         end
         if (done) begin
            check("done_cycle",  32'(cyc), 32'(exp_done_t));
            check("done_m_idx",  32'(m_idx), 32'(m_eff - 1));
            check("done_c_idx",  32'(c_idx), 32'(c_eff - 1));
            n_done++;
            fin = 1;
         end
         load_done = ld_tied || (cyc == ld_t);
         pass_done = (cyc == pd_t) || (cyc == inj_t);
         start     = (cyc == inj_t);
         if (cyc == inj_t) begin
            num_m_passes = 8'($urandom_range(1, 255));
            num_c_passes = 8'($urandom_range(1, 255));
         end
         step();
      end
      start = 1'b0;
      load_done = 1'b0;
      pass_done = 1'b0;
      if (!aborted) begin
         check("finished",    32'(fin), 1);
         check("load_pulses", 32'(n_load), 32'(total));
         check("pass_pulses", 32'(n_pass), 32'(total));
         check("done_pulses", 32'(n_done), 1);
         check("after_done",  32'(done), 0);
         check("after_busy",  32'(busy), 0);
         check("held_m_idx",  32'(m_idx), 32'(m_eff - 1));
         check("held_c_idx",  32'(c_idx), 32'(c_eff - 1));
      end
   endtask

   initial begin
      int rm, rc;
      rst_last_c = (0 == ((0 - 1) & 255)) ? 1 : 0;
      reset = 1'b1;
      start = 1'b0;
      load_done = 1'b0;
      pass_done = 1'b0;
      num_m_passes = 8'd0;
      num_c_passes = 8'd0;
      step();
      step();
      check_reset_state("reset");
      reset = 1'b0;
      step();
      check_reset_state("idle");

      // reset during the second pass, then a clean 2x2 layer
      run_layer(2, 2, 2, 2, 0, 0, 2);
      run_layer(2, 2, 2, 2, 0, 0, 0);
      // basic 2x3 with 3-cycle responders
      run_layer(2, 3, 3, 3, 0, 0, 0);
      // zero counts give a single pass
      run_layer(0, 0, 2, 2, 0, 0, 0);
      // stray start and pass_done during WAIT_LOAD
      run_layer(2, 2, 3, 2, 0, 1, 0);
      // load_done tied high, pass_done 2 cycles after pass_start
      run_layer(1, 2, 1, 2, 1, 0, 0);
      // full-width channel count
      run_layer(1, 255, 1, 1, 0, 0, 0);
      // randomized layers
      for (int i = 0; i < 6; i++) begin
         rm = $urandom_range(0, 4);
         rc = $urandom_range(0, 5);
         run_layer(rm, rc, $urandom_range(2, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
